// File: rtl/run_len_detector_if.sv
// Sample/result bundle for run_len_detector: shared sample strobe, per-channel
// serial bits, shared threshold/mode, and per-channel detection and busy flags.
interface run_len_detector_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
);
    logic                in_valid;
    logic [CHANNELS-1:0] in;
    logic [CNT_W-1:0]    thresh;
    logic                mode;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] busy;

    modport master (output in_valid, in, thresh, mode, input out, busy);
    modport slave  (input in_valid, in, thresh, mode, output out, busy);
endinterface

// File: rtl/run_len_detector.sv
// Multi-channel run-length detector: flags runs of valid 1s reaching a shared threshold.
// Define RUN_LEN_DETECTOR_REG_OUT_EN to register out (one cycle of latency).
//
// state | meaning
// IDLE  | no 1s in the current run
// COUNT | run in progress, threshold not yet reached
// HIT   | threshold reached in this run (held until a valid 0)
module run_len_detector #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
) (
    input logic               clk,
    input logic               rst,
    run_len_detector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, HIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    thr_eff;
    logic [CHANNELS-1:0] out_w;
    logic [CHANNELS-1:0] busy_w;

    assign thr_eff  = (bus.thresh == '0) ? CNT_W'(1) : bus.thresh;
    assign bus.out  = out_w;
    assign bus.busy = busy_w;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             busy_q;
        logic [CNT_W:0]   run_now;
        logic             hit;
        logic             out_d;

        // run_now is one bit wider than cnt so a saturated count never wraps below thresh
        assign run_now = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        assign hit     = bus.in_valid & bus.in[c] & (run_now >= {1'b0, thr_eff});

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            out_d   = 1'b0;
            if (!rst) begin
                out_d = bus.mode ? (hit & (state_q != HIT)) : hit;
            end
            if (bus.in_valid) begin
                if (bus.in[c]) begin
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = (hit || state_q == HIT) ? HIT : COUNT;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                busy_q  <= (state_d != IDLE);
            end
        end

        assign busy_w[c] = busy_q;

`ifdef RUN_LEN_DETECTOR_REG_OUT_EN
        logic out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= 1'b0;
            end else begin
                out_q <= out_d;
            end
        end

        assign out_w[c] = out_q;
`else
        assign out_w[c] = out_d;
`endif
    end
endmodule

// File: tb/tb_run_len_detector.sv
// Directed self-checking bench for run_len_detector: a 4-channel/4-bit instance
// and a 1-channel/3-bit instance for saturation.
module tb_run_len_detector;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] prev_a = '0;
    logic       prev_b = 1'b0;

    run_len_detector_if #(.CHANNELS(4), .CNT_W(4)) a_if ();
    run_len_detector_if #(.CHANNELS(1), .CNT_W(3)) b_if ();

    run_len_detector #(.CHANNELS(4), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    run_len_detector #(.CHANNELS(1), .CNT_W(3)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sample cycle on instance A; out checked against the Mealy value
    // (or the previous cycle's value when the output is registered).
    task automatic step_a(input logic v, input logic [3:0] d, input logic [3:0] eo,
                          input logic [3:0] eb, input string tag);
        logic [3:0] want;
        a_if.in_valid = v;
        a_if.in       = d;
        @(negedge clk);
`ifdef RUN_LEN_DETECTOR_REG_OUT_EN
        want = prev_a;
`else
        want = eo;
`endif
        prev_a = eo;
        checks++;
        assert (a_if.out === want) else begin
            errors++;
            $error("FAIL %s out: got %b expected %b", tag, a_if.out, want);
        end
        checks++;
        assert (a_if.busy === eb) else begin
            errors++;
            $error("FAIL %s busy: got %b expected %b", tag, a_if.busy, eb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic d, input logic eo, input string tag);
        logic want;
        b_if.in_valid = v;
        b_if.in       = d;
        @(negedge clk);
`ifdef RUN_LEN_DETECTOR_REG_OUT_EN
        want = prev_b;
`else
        want = eo;
`endif
        prev_b = eo;
        checks++;
        assert (b_if.out === want) else begin
            errors++;
            $error("FAIL %s out: got %b expected %b", tag, b_if.out, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_if.in_valid = 1'b0; a_if.in = '0; a_if.thresh = 4'd2; a_if.mode = 1'b0;
        b_if.in_valid = 1'b0; b_if.in = '0; b_if.thresh = 3'd7; b_if.mode = 1'b0;
        @(posedge clk);
        #1;
        // reset: out forced low even with valid 1s present
        step_a(1, 4'b1111, 4'b0000, 4'b0000, "reset");
        rst = 1'b0;

        // equivalence with the two-in-a-row detector
        a_if.thresh = 4'd2; a_if.mode = 1'b0;
        step_a(1, 4'b0000, 4'b0000, 4'b0000, "eq0");
        step_a(1, 4'b0001, 4'b0000, 4'b0000, "eq1");
        step_a(1, 4'b0001, 4'b0001, 4'b0001, "eq2");
        step_a(1, 4'b0001, 4'b0001, 4'b0001, "eq3");
        step_a(1, 4'b0000, 4'b0000, 4'b0001, "eq4");
        step_a(1, 4'b0001, 4'b0000, 4'b0000, "eq5");
        step_a(1, 4'b0001, 4'b0001, 4'b0001, "eq6");
        step_a(1, 4'b0000, 4'b0000, 4'b0001, "eq_clr");

        // pulse mode, thresh 3, six 1s then 0
        a_if.thresh = 4'd3; a_if.mode = 1'b1;
        step_a(1, 4'b0001, 4'b0000, 4'b0000, "pulse1");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "pulse2");
        step_a(1, 4'b0001, 4'b0001, 4'b0001, "pulse3");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "pulse4");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "pulse5");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "pulse6");
        step_a(1, 4'b0000, 4'b0000, 4'b0001, "pulse_end");
        step_a(1, 4'b0000, 4'b0000, 4'b0000, "pulse_idle");

        // invalid cycles neither break nor extend a run
        a_if.mode = 1'b0;
        step_a(1, 4'b0001, 4'b0000, 4'b0000, "gap1");
        step_a(0, 4'b0001, 4'b0000, 4'b0001, "gap2");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "gap3");
        step_a(0, 4'b0000, 4'b0000, 4'b0001, "gap4");
        step_a(1, 4'b0001, 4'b0001, 4'b0001, "gap5");
        step_a(1, 4'b0000, 4'b0000, 4'b0001, "gap_clr");

        // thresh 0 behaves as 1
        a_if.thresh = 4'd0;
        step_a(1, 4'b0101, 4'b0101, 4'b0000, "thr0_a");
        step_a(0, 4'b1111, 4'b0000, 4'b0101, "thr0_inv");
        step_a(1, 4'b1010, 4'b1010, 4'b0101, "thr0_b");
        step_a(1, 4'b0000, 4'b0000, 4'b1010, "thr0_clr");

        // live threshold: lower 8 -> 3 at cnt=4, then raise while in HIT
        a_if.thresh = 4'd8;
        step_a(1, 4'b0001, 4'b0000, 4'b0000, "thr_r1");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "thr_r2");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "thr_r3");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "thr_r4");
        a_if.thresh = 4'd3;
        step_a(1, 4'b0001, 4'b0001, 4'b0001, "thr_lower");
        a_if.thresh = 4'd8;
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "thr_raise");
        a_if.thresh = 4'd3; a_if.mode = 1'b1;
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "mode_in_hit");
        a_if.mode = 1'b0;
        step_a(1, 4'b0000, 4'b0000, 4'b0001, "thr_clr");

        // reset mid-run; restarted run needs the full threshold
        step_a(1, 4'b0001, 4'b0000, 4'b0000, "mrst1");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "mrst2");
        rst = 1'b1;
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "mrst_rst");
        rst = 1'b0;
        step_a(1, 4'b0001, 4'b0000, 4'b0000, "mrst_r1");
        step_a(1, 4'b0001, 4'b0000, 4'b0001, "mrst_r2");
        step_a(1, 4'b0001, 4'b0001, 4'b0001, "mrst_r3");
        step_a(1, 4'b0000, 4'b0000, 4'b0001, "mrst_clr");

        // channel independence
        a_if.thresh = 4'd2;
        step_a(1, 4'b1010, 4'b0000, 4'b0000, "multi1");
        step_a(1, 4'b1111, 4'b1010, 4'b1010, "multi2");
        step_a(1, 4'b0000, 4'b0000, 4'b1111, "multi_clr");
        a_if.in_valid = 1'b0;

        // saturation with 3-bit counter, thresh 7: level then pulse
        b_if.thresh = 3'd7; b_if.mode = 1'b0;
        for (int i = 1; i <= 20; i++) step_b(1, 1'b1, (i >= 7), $sformatf("sat_lvl%0d", i));
        step_b(1, 1'b0, 1'b0, "sat_lvl_clr");
        b_if.mode = 1'b1;
        for (int i = 1; i <= 20; i++) step_b(1, 1'b1, (i == 7), $sformatf("sat_pls%0d", i));
        step_b(1, 1'b0, 1'b0, "sat_pls_clr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/run_len_detector.md
Name: run_len_detector

Overview:
- Multi-channel, parametrised successor to the single-bit "consecutive 1s" Mealy detector.
- Each channel asserts its output when its serial input has been 1 for at least a programmable number of consecutive valid samples, counting the current sample.
- Two output modes: level and single pulse per run.
- Sits after input synchronisers and feeds event/interrupt logic. All channels share one threshold and one mode.

Parameters:
CHANNELS, 4, number of independent detector channels (>=1)
CNT_W, 4, run counter width; maximum usable threshold is 2^CNT_W-1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  sample strobe; in[] is sampled only when 1
in  input  CHANNELS  serial data, one bit per channel
thresh  input  CNT_W  required run length; value 0 is treated as 1
mode  input  1  0 = level output, 1 = pulse output
out  output  CHANNELS  detection output per channel (Mealy, combinational from in/in_valid/state)
busy  output  CHANNELS  1 when channel state is not IDLE (registered)

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high, sampled on the rising edge of clk.
- Reset, per channel:
  - cnt=0, state=IDLE.
  - busy=0.
  - out forced to 0 combinationally whenever rst=1.
- Per-channel state machine, states IDLE, COUNT, HIT:
  - IDLE: no 1s in the current run.
  - COUNT: run in progress, threshold not yet reached.
  - HIT: threshold reached in this run.
- cnt holds the number of consecutive valid 1 samples before the current sample, saturating at 2^CNT_W-1.
- thr_eff = (thresh==0) ? 1 : thresh.
- run_now = cnt+1, computed in CNT_W+1 bits; no wrap.
- hit = in_valid & in[c] & (run_now >= thr_eff).
- Output, zero latency, same cycle as the sample:
  - mode=0: out[c] = hit.
  - mode=1: out[c] = hit & (state != HIT), i.e. exactly one cycle per run.
- Next-state on a clock edge with in_valid=1:
  - in[c]=1: cnt <= min(cnt+1, 2^CNT_W-1); state <= HIT if hit, else COUNT.
  - in[c]=0: cnt <= 0; state <= IDLE.
- in_valid=0: cnt and state hold; out=0. Invalid cycles neither break nor extend a run.
- Threshold change mid-run: compared live every cycle.
  - Lowering thresh can produce a hit on the next valid 1.
  - A channel already in HIT stays in HIT until a valid 0, including if thresh is raised. In mode=1 no second pulse is produced within the same run.
- Mode change mid-run: takes effect on the same cycle. Switching to pulse while in HIT gives out=0 until a new run.
- Saturation: a run longer than 2^CNT_W-1 keeps cnt at max; hit stays true. No wrap to 0 and no spurious re-pulse.
- Reset mid-run: clears all channels on that edge. The first valid sample after reset starts a new run.
- Channels are fully independent; simultaneous hits on all channels are allowed.
- Equivalence with the earlier detector: CHANNELS=1, thresh=2, mode=0, in_valid=1 gives out = in & (previous in).

Optional Feature:
- Macro: RUN_LEN_DETECTOR_REG_OUT_EN.
- Defined:
  - out is registered (Moore-style): out_q[c] <= the combinational value defined above, giving one cycle of latency.
  - out_q resets to 0 and is forced to 0 on the cycle following rst.
  - busy is unchanged.
- Not defined: out is the combinational Mealy output with zero latency, as specified above.

Test Plan:
1. Equivalence: CHANNELS=1, thresh=2, mode=0, in_valid=1, in=0,1,1,1,0,1,1 -> out=0,0,1,1,0,0,1.
2. Pulse mode: thresh=3, mode=1, in=1 for 6 cycles then 0 -> out=1 only on the 3rd 1-cycle; busy=1 from the cycle after the first 1 until the cycle after the 0.
3. in_valid gaps: thresh=3, mode=0, pattern (valid,in)=(1,1),(0,x),(1,1),(0,0),(1,1) -> out=1 only on the 5th cycle.
4. Saturation: CNT_W=3, thresh=7, mode=0, in=1 for 20 cycles -> out=1 from cycle 7 through 20 continuously, no drop. mode=1 gives a single pulse at cycle 7.
5. Threshold/reset edge cases:
   - thresh=0 -> behaves as 1, out=in&in_valid.
   - Run at cnt=4 with thresh 8 lowered to 3 -> out=1 on the next valid 1.
   - rst asserted mid-run -> out=0 that cycle; a restarted run needs the full thresh.
6. Multi-channel independence: CHANNELS=4, thresh=2, in=4'b1010 then 4'b1111 -> out=4'b0000 then 4'b1010. With RUN_LEN_DETECTOR_REG_OUT_EN defined, the same out values appear one cycle later.
